// File: rtl/ysyx_22050612_ifu_pkg.sv
// ysyx_22050612_ifu_pkg: shared states and constants for the instruction fetch unit
package ysyx_22050612_ifu_pkg;
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_HALT} state_e;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;
  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
  localparam logic [63:0] INST_STEP = 64'd4;
endpackage

// File: rtl/ysyx_22050612_ifu_wsel.sv
// ysyx_22050612_ifu_wsel: picks the 32-bit instruction word out of a fetched doubleword
module ysyx_22050612_ifu_wsel (
  input  logic [63:0] data,
  input  logic        sel,
  output logic [31:0] word
);
  assign word = sel ? data[63:32] : data[31:0];
endmodule

// File: rtl/ysyx_22050612_ifu.sv
// ysyx_22050612_ifu: single-outstanding instruction fetch with redirect and decode handshake
// Define IFU_EBREAK_HALT_EN to stop fetching after an ebreak is handed to decode.
module ysyx_22050612_ifu
  import ysyx_22050612_ifu_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          ADDR_W   = 64
) (
  input  logic              clk,
  input  logic              rst,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              resp_valid,
  input  logic [63:0]       resp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INST_STEP);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, target;
  logic drop_q, drop_d;
  logic [31:0] inst_q, inst_d, word;
  ysyx_22050612_ifu_wsel u_wsel (.data(resp_data), .sel(pc_q[2]), .word(word));
  assign target = redirect_pc & ~ADDR_W'(3);
  assign req_valid = rst && state_q == S_REQ;
  assign inst_valid = rst && state_q == S_HOLD;
  assign req_addr = pc_q & ~ADDR_W'(7);
  assign inst = inst_q;
  assign inst_pc = pc_q;
`ifdef IFU_EBREAK_HALT_EN
  assign halted = rst && state_q == S_HALT;
`else
  assign halted = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    drop_d = drop_q;
    inst_d = inst_q;
    case (state_q)
      S_REQ: begin
        pc_d = redirect_valid ? target : pc_q;
        if (req_ready) begin
          state_d = S_WAIT;
          drop_d = redirect_valid;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d = target;
          drop_d = !resp_valid;
          state_d = resp_valid ? S_REQ : S_WAIT;
        end else if (resp_valid) begin
          drop_d = 1'b0;
          inst_d = drop_q ? inst_q : word;
          state_d = drop_q ? S_REQ : S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d = target;
          state_d = S_REQ;
        end else if (inst_ready) begin
`ifdef IFU_EBREAK_HALT_EN
          pc_d = inst_q == EBREAK_INST ? pc_q : pc_q + STEP;
          state_d = inst_q == EBREAK_INST ? S_HALT : S_REQ;
`else
          pc_d = pc_q + STEP;
          state_d = S_REQ;
`endif
        end
      end
      default: state_d = state_q;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_REQ;
      pc_q <= ADDR_W'(RESET_PC);
      drop_q <= 1'b0;
      inst_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      drop_q <= drop_d;
      inst_q <= inst_d;
    end
  end
endmodule

// File: tb/tb_ysyx_22050612_ifu.sv
// tb_ysyx_22050612_ifu: vector table plus directed redirect/reset/ebreak sequences against a scoreboard
module tb_ysyx_22050612_ifu;
  logic clk, rst, req_valid, req_ready, resp_valid, inst_valid, inst_ready, redirect_valid, halted;
  logic [63:0] req_addr, resp_data, inst_pc, redirect_pc, ra, last_addr;
  logic [31:0] inst;
  logic mem_en;
  int lat, tests, fails;
  typedef struct {logic [63:0] pc; logic [31:0] inst;} exp_t;
  typedef struct {int stall; logic [63:0] pc; logic [31:0] inst; logic [63:0] next_addr;} vec_t;
  exp_t sb[$];
  vec_t tv[5];

  ysyx_22050612_ifu dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halted(halted)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mem(input logic [63:0] a);
    logic [31:0] k;
    k = 32'hCAFE_0000;
    if (a == 64'h8000_0000) return 64'h00000013_00100093;
    if (a == 64'h8000_0300) return 64'h00000013_00100073;
    return {(a[31:0] + 32'd4) ^ k, a[31:0] ^ k};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!inst_valid && n < 20) begin
      step();
      n++;
    end
    chk("inst_valid_wait", {63'd0, inst_valid}, 64'd1);
  endtask

  task automatic take(input logic [63:0] pc, input logic [31:0] in, input int stall);
    exp_t e;
    wait_valid();
    e.pc = pc;
    e.inst = in;
    sb.push_back(e);
    inst_ready = 0;
    repeat (stall) begin
      step();
      chk("stall_inst", {32'd0, inst}, {32'd0, in});
      chk("stall_pc", inst_pc, pc);
      chk("stall_no_req", {63'd0, req_valid}, 64'd0);
    end
    inst_ready = 1;
    step();
    inst_ready = 0;
  endtask

  task automatic do_reset();
    mem_en = 0;
    req_ready = 0;
    inst_ready = 0;
    redirect_valid = 0;
    rst = 0;
    repeat (6) step();
    lat = 1;
  endtask

  initial begin
    resp_valid = 0;
    resp_data = '0;
    last_addr = '0;
    forever begin
      @(negedge clk);
      if (mem_en && rst && req_valid && req_ready) begin
        ra = req_addr;
        last_addr = ra;
        @(posedge clk);
        repeat (lat - 1) @(posedge clk);
        #1;
        resp_valid = 1;
        resp_data = mem(ra);
        @(posedge clk);
        #1;
        resp_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst && inst_valid && inst_ready && !redirect_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got inst %h pc %h expected none", inst, inst_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_inst", {32'd0, inst}, {32'd0, e.inst});
        chk("sb_pc", inst_pc, e.pc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tv[0] = '{0, 64'h8000_0000, 32'h0010_0093, 64'h8000_0000};
    tv[1] = '{5, 64'h8000_0004, 32'h0000_0013, 64'h8000_0008};
    tv[2] = '{0, 64'h8000_0008, 32'h4AFE_0008, 64'h8000_0008};
    tv[3] = '{2, 64'h8000_000C, 32'h4AFE_000C, 64'h8000_0010};
    tv[4] = '{0, 64'h8000_0010, 32'h4AFE_0010, 64'h8000_0010};
    tests = 0;
    fails = 0;
    redirect_pc = '0;
    resp_data = '0;
    do_reset();
    chk("rst_req_valid", {63'd0, req_valid}, 64'd0);
    chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
    chk("rst_pc", inst_pc, 64'h8000_0000);
    chk("rst_inst", {32'd0, inst}, 64'd0);
    chk("rst_halted", {63'd0, halted}, 64'd0);
    mem_en = 1;
    req_ready = 1;
    rst = 1;
    #1;
    chk("first_req_valid", {63'd0, req_valid}, 64'd1);
    chk("first_req_addr", req_addr, 64'h8000_0000);
    foreach (tv[i]) begin
      take(tv[i].pc, tv[i].inst, tv[i].stall);
      chk("next_req_valid", {63'd0, req_valid}, 64'd1);
      chk("next_req_addr", req_addr, tv[i].next_addr);
    end
    // redirect while waiting: late response must be dropped
    do_reset();
    lat = 3;
    mem_en = 1;
    req_ready = 1;
    rst = 1;
    step();
    chk("wait_no_req", {63'd0, req_valid}, 64'd0);
    redirect_valid = 1;
    redirect_pc = 64'h8000_0100;
    step();
    redirect_valid = 0;
    chk("wait_redir_pc", inst_pc, 64'h8000_0100);
    chk("wait_redir_no_req", {63'd0, req_valid}, 64'd0);
    take(64'h8000_0100, 32'h4AFE_0100, 0);
    chk("wait_redir_addr", last_addr, 64'h8000_0100);
    // redirect coincident with response, then with decode handshake
    do_reset();
    req_ready = 1;
    rst = 1;
    step();
    req_ready = 0;
    resp_valid = 1;
    resp_data = mem(64'h8000_0000);
    redirect_valid = 1;
    redirect_pc = 64'h8000_0102;
    step();
    resp_valid = 0;
    redirect_valid = 0;
    chk("resp_redir_inst_valid", {63'd0, inst_valid}, 64'd0);
    chk("resp_redir_req_valid", {63'd0, req_valid}, 64'd1);
    chk("resp_redir_addr", req_addr, 64'h8000_0100);
    mem_en = 1;
    req_ready = 1;
    wait_valid();
    chk("hold_pc", inst_pc, 64'h8000_0100);
    inst_ready = 1;
    redirect_valid = 1;
    redirect_pc = 64'h8000_0202;
    step();
    inst_ready = 0;
    redirect_valid = 0;
    chk("hold_redir_inst_valid", {63'd0, inst_valid}, 64'd0);
    chk("hold_redir_pc", inst_pc, 64'h8000_0200);
    chk("hold_redir_addr", req_addr, 64'h8000_0200);
    take(64'h8000_0200, 32'h4AFE_0200, 0);
    // reset in the middle of a fetch, stale response afterwards
    do_reset();
    req_ready = 1;
    rst = 1;
    step();
    req_ready = 0;
    chk("mid_wait_no_req", {63'd0, req_valid}, 64'd0);
    rst = 0;
    #1;
    chk("rst_low_req_valid", {63'd0, req_valid}, 64'd0);
    step();
    chk("mid_rst_req_valid", {63'd0, req_valid}, 64'd0);
    chk("mid_rst_inst_valid", {63'd0, inst_valid}, 64'd0);
    chk("mid_rst_pc", inst_pc, 64'h8000_0000);
    rst = 1;
    resp_valid = 1;
    resp_data = 64'hDEAD_BEEF_DEAD_BEEF;
    step();
    resp_valid = 0;
    chk("stale_inst_valid", {63'd0, inst_valid}, 64'd0);
    chk("stale_inst", {32'd0, inst}, 64'd0);
    chk("stale_req_valid", {63'd0, req_valid}, 64'd1);
    chk("stale_req_addr", req_addr, 64'h8000_0000);
    mem_en = 1;
    req_ready = 1;
    take(64'h8000_0000, 32'h0010_0093, 0);
    req_ready = 0;
    mem_en = 0;
    // ebreak handling
    redirect_valid = 1;
    redirect_pc = 64'h8000_0300;
    step();
    redirect_valid = 0;
    chk("ebreak_addr", req_addr, 64'h8000_0300);
    mem_en = 1;
    req_ready = 1;
    take(64'h8000_0300, 32'h0010_0073, 0);
`ifdef IFU_EBREAK_HALT_EN
    chk("halt_halted", {63'd0, halted}, 64'd1);
    chk("halt_req_valid", {63'd0, req_valid}, 64'd0);
    chk("halt_inst_valid", {63'd0, inst_valid}, 64'd0);
    redirect_valid = 1;
    redirect_pc = 64'h8000_0100;
    step();
    step();
    redirect_valid = 0;
    chk("halt_redir_req", {63'd0, req_valid}, 64'd0);
    chk("halt_redir_pc", inst_pc, 64'h8000_0300);
    chk("halt_stays", {63'd0, halted}, 64'd1);
`else
    chk("no_halt", {63'd0, halted}, 64'd0);
    take(64'h8000_0304, 32'h0000_0013, 0);
`endif
    req_ready = 0;
    mem_en = 0;
    repeat (3) step();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
